// File: rtl/bancoregs_pkg.sv
// bancoregs_pkg
//   Shared constants and types for the banco_regs_param register bank:
//   default widths, clear-sequencer state encoding and the hardwired-zero
//   register address.
package bancoregs_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register that reads as zero when R0_ZERO is set.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/bancoregs_scoreboard.sv
// bancoregs_scoreboard
//   Pending-write scoreboard: one bit per register, set when decode issues a
//   producer and cleared when writeback commits the value. A set and a clear
//   to the same address in one cycle leaves the bit set, because the set
//   belongs to a newer producer.
//   Ports:
//     clk, reset          clock, synchronous active-high reset (clears all bits)
//     set_en, set_addr    qualified set request
//     clr_en, clr_addr    qualified clear request (accepted write)
//     look_addr           NUM_RD packed lookup addresses
//     look_pend           stored pending bit for each lookup address
module bancoregs_scoreboard
  import bancoregs_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] look_addr,
  output logic [NUM_RD-1:0]        look_pend
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;

  // Clear first, then set, so a same-address collision resolves to set.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_addr] = 1'b0;
    if (set_en) pend_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= pend_nxt;
  end

  always_comb begin
    look_pend = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      look_pend[i] = pend[look_addr[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/banco_regs_param.sv
// banco_regs_param
//   Parametrised MIPS register bank: NUM_RD combinational read ports, one
//   clocked write port, a clear sequencer that zeroes every register after
//   reset, and a pending-write scoreboard for hazard detection.
//   Optional feature macro: BANCOREGS_BYPASS_EN -- when defined, an accepted
//   write is forwarded to matching read ports in the same cycle and their
//   pending bit is masked (unless a new producer targets the same address).
//   Ports:
//     clk, reset    clock, synchronous active-high reset
//     init_busy     high while the clear sequencer runs
//     rd_addr       packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//     rd_data       packed read data, port i at [i*DATA_W +: DATA_W]
//     rd_pending    scoreboard bit per read port
//     wr_en, wr_addr, wr_data   write port
//     sb_set, sb_addr           mark a register as having an in-flight producer
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | writes 0 to regs[clr_ptr] each cycle; writes/sb_set ignored
//   ST_RUN   | normal operation
module banco_regs_param
  import bancoregs_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = 2,
  parameter int R0_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     init_busy,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_we;
  logic              run_en;
  logic              wr_acc;
  logic              set_acc;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [NUM_RD-1:0] pend_raw;

  // State register: any reset cycle restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_ptr == '1) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Reset dominates: nothing is written or marked on a cycle with reset high.
  always_comb begin
    init_busy = 1'b1;
    clr_we    = 1'b0;
    run_en    = 1'b0;
    case (state)
      ST_CLEAR: begin
        init_busy = 1'b1;
        clr_we    = !reset;
      end
      ST_RUN: begin
        init_busy = 1'b0;
        run_en    = !reset;
      end
      default: begin
        init_busy = 1'b1;
      end
    endcase
  end

  // Held at 0 during reset so the sweep takes exactly DEPTH cycles after it.
  always_ff @(posedge clk) begin
    if (reset)       clr_ptr <= '0;
    else if (clr_we) clr_ptr <= clr_ptr + ADDR_W'(1);
  end

  assign wr_acc  = run_en && wr_en  && !((R0_ZERO != 0) && (wr_addr == ZERO_ADDR));
  assign set_acc = run_en && sb_set && !((R0_ZERO != 0) && (sb_addr == ZERO_ADDR));

  always_ff @(posedge clk) begin
    if (clr_we)      regs[clr_ptr] <= '0;
    else if (wr_acc) regs[wr_addr] <= wr_data;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_ra
    assign ra[g] = rd_addr[g*ADDR_W +: ADDR_W];
  end

  bancoregs_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (set_acc),
    .set_addr  (sb_addr),
    .clr_en    (wr_acc),
    .clr_addr  (wr_addr),
    .look_addr (rd_addr),
    .look_pend (pend_raw)
  );

  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = regs[ra[i]];
      rd_pending[i]               = pend_raw[i];
`ifdef BANCOREGS_BYPASS_EN
      if (wr_acc && (wr_addr == ra[i])) begin
        rd_data[i*DATA_W +: DATA_W] = wr_data;
        if (!(set_acc && (sb_addr == ra[i]))) rd_pending[i] = 1'b0;
      end
`endif
      if ((R0_ZERO != 0) && (ra[i] == ZERO_ADDR)) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_pending[i]               = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_banco_regs_param.sv
// tb_banco_regs_param
//   Self-checking bench for banco_regs_param with three read ports.
//   Expected values are queued when stimulus is applied and popped when the
//   DUT outputs are sampled (half a cycle away from the rising edge).
module tb_banco_regs_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     init_busy;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;

  banco_regs_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .R0_ZERO (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .init_busy  (init_busy),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .sb_set     (sb_set),
    .sb_addr    (sb_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t expq[$];

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        st;
    logic [4:0]  sa;
    logic [4:0]  r0, r1, r2;
    logic [31:0] e0, e1, e2;
    logic [2:0]  ep;
  } vec_t;

  vec_t vt[10];

  task automatic push_exp(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    expq.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    exp_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL queue_empty actual=%h", act);
    end else begin
      e = expq.pop_front();
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
      end
    end
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  function automatic logic [31:0] rd(input int p);
    return rd_data[p*DATA_W +: DATA_W];
  endfunction

  // Called #1 after the negedge on which reset was dropped; ends at the same
  // phase of the first cycle with init_busy low.
  task automatic run_clear(input string n);
    int cnt;
    cnt = 0;
    push_exp(n, 32);
    while (init_busy === 1'b1 && cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      #1;
    end
    pop_cmp(cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 5'd8,  32'h0000_0005, 1'b0, 5'd0,  5'd8,  5'd8,  5'd0,  32'h5, 32'h5, 32'h0, 3'b000};
    vt[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  5'd0,  5'd8,  5'd0,  32'h0, 32'h5, 32'h0, 3'b000};
    vt[2] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 3'b000};
    vt[3] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  5'd9,  5'd8,  5'd9,  32'h0, 32'h5, 32'h0, 3'b101};
    vt[4] = '{1'b1, 5'd9,  32'h4,         1'b0, 5'd0,  5'd9,  5'd9,  5'd9,  32'h4, 32'h4, 32'h4, 3'b000};
    vt[5] = '{1'b1, 5'd9,  32'h7,         1'b1, 5'd9,  5'd9,  5'd1,  5'd9,  32'h7, 32'h0, 32'h7, 3'b101};
    vt[6] = '{1'b1, 5'd14, 32'hFF,        1'b0, 5'd0,  5'd14, 5'd14, 5'd14, 32'hFF, 32'hFF, 32'hFF, 3'b000};
    vt[7] = '{1'b1, 5'd9,  32'h8,         1'b1, 5'd20, 5'd20, 5'd9,  5'd14, 32'h0, 32'h8, 32'hFF, 3'b001};
    vt[8] = '{1'b1, 5'd31, 32'hDEAD_BEEF, 1'b0, 5'd0,  5'd31, 5'd30, 5'd20, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'b100};
    vt[9] = '{1'b1, 5'd20, 32'h1,         1'b0, 5'd0,  5'd20, 5'd14, 5'd8,  32'h1, 32'hFF, 32'h5, 3'b000};

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
    set_rd(5'd0, 5'd1, 5'd2);

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    push_exp("reset_init_busy", 32'd1);
    pop_cmp({31'd0, init_busy});
    push_exp("reset_rd_pending", 32'd0);
    pop_cmp({29'd0, rd_pending});

    reset = 1'b0;
    #1;
    run_clear("clear_cycles");

    // Every register reads 0 and nothing is pending after the sweep.
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'((a + 1) % 32), 5'((a + 2) % 32));
      #1;
      push_exp($sformatf("clear_data_a%0d", a), 32'h0);
      pop_cmp(rd(0) | rd(1) | rd(2));
      push_exp($sformatf("clear_pend_a%0d", a), 32'h0);
      pop_cmp({29'd0, rd_pending});
    end

    // Table vectors: one cycle of write/set, then read in the following cycle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr_en   = vt[i].wr;
      wr_addr = vt[i].wa;
      wr_data = vt[i].wd;
      sb_set  = vt[i].st;
      sb_addr = vt[i].sa;
      push_exp($sformatf("vec%0d_rd0", i), vt[i].e0);
      push_exp($sformatf("vec%0d_rd1", i), vt[i].e1);
      push_exp($sformatf("vec%0d_rd2", i), vt[i].e2);
      push_exp($sformatf("vec%0d_pend", i), {29'd0, vt[i].ep});
      @(posedge clk);
      @(negedge clk);
      wr_en  = 1'b0;
      sb_set = 1'b0;
      set_rd(vt[i].r0, vt[i].r1, vt[i].r2);
      #1;
      pop_cmp(rd(0));
      pop_cmp(rd(1));
      pop_cmp(rd(2));
      pop_cmp({29'd0, rd_pending});
    end

    // Same-cycle read of a register being written while it is pending.
    @(negedge clk);
    sb_set  = 1'b1;
    sb_addr = 5'd8;
    @(posedge clk);
    @(negedge clk);
    sb_set  = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd8;
    wr_data = 32'h55;
    set_rd(5'd8, 5'd8, 5'd14);
    #1;
`ifdef BANCOREGS_BYPASS_EN
    push_exp("same_cycle_data", 32'h55);
    push_exp("same_cycle_pend", 32'd0);
`else
    push_exp("same_cycle_data", 32'h5);
    push_exp("same_cycle_pend", 32'd1);
`endif
    pop_cmp(rd(0));
    pop_cmp({31'd0, rd_pending[0]});
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    push_exp("after_write_data", 32'h55);
    pop_cmp(rd(1));
    push_exp("after_write_pend", 32'd0);
    pop_cmp({31'd0, rd_pending[1]});

    // Mid-run reset: writes and sets during the sweep must leave no trace.
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 5'd12;
    wr_data = 32'h10;
    sb_set  = 1'b1;
    sb_addr = 5'd25;
    @(posedge clk);
    @(negedge clk);
    wr_en  = 1'b0;
    sb_set = 1'b0;
    set_rd(5'd12, 5'd25, 5'd0);
    #1;
    push_exp("pre_reset_data12", 32'h10);
    pop_cmp(rd(0));
    push_exp("pre_reset_pend", 32'd2);
    pop_cmp({29'd0, rd_pending});

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd12;
    wr_data = 32'h99;
    sb_set  = 1'b1;
    sb_addr = 5'd12;
    #1;
    push_exp("midrun_init_busy", 32'd1);
    pop_cmp({31'd0, init_busy});
    run_clear("midrun_clear_cycles");
    wr_en  = 1'b0;
    sb_set = 1'b0;
    set_rd(5'd12, 5'd25, 5'd31);
    #1;
    push_exp("post_clear_data12", 32'h0);
    pop_cmp(rd(0));
    push_exp("post_clear_data31", 32'h0);
    pop_cmp(rd(2));
    push_exp("post_clear_pend", 32'd0);
    pop_cmp({29'd0, rd_pending});

    // Run continues normally after the second sweep.
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 5'd12;
    wr_data = 32'hA5A5_0001;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    push_exp("post_clear_write12", 32'hA5A5_0001);
    pop_cmp(rd(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
